// File: rtl/lobster_dbus_unit.sv
// Single-port SRAM arbiter for the lobster core: an instruction prefetch queue with
// redirect/flush, plus a sized load/store channel that shares one ce/we/rdy port.
`timescale 1ns/1ps
module lobster_dbus_unit #(
    parameter int                    ADDR_WIDTH  = 36,
    parameter int                    FETCH_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 'hF800
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rdy,
    output logic                  o_ce,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr_in,
    input  logic [63:0]           i_data_in,
    output logic [ADDR_WIDTH-1:0] o_addr_out,
    output logic [63:0]           o_data_out,
    output logic [7:0]            o_wstrb,
    input  logic                  i_redir_valid,
    input  logic [ADDR_WIDTH-1:0] i_redir_pc,
    output logic                  o_if_valid,
    input  logic                  i_if_ready,
    output logic [63:0]           o_if_insn,
    output logic [ADDR_WIDTH-1:0] o_if_pc,
    input  logic                  i_ls_req,
    input  logic                  i_ls_we,
    input  logic [1:0]            i_ls_size,
    input  logic [ADDR_WIDTH-1:0] i_ls_addr,
    input  logic [63:0]           i_ls_wdata,
    output logic                  o_ls_ack,
    output logic [63:0]           o_ls_rdata,
    output logic                  o_ls_err,
    output logic [1:0]            o_dbg_state
);

    localparam int PW = $clog2(FETCH_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(7);

    // Handshakes: an SRAM op is ce held high until rdy is sampled; the fetch queue pops
    // on if_valid & if_ready; ls_req stays high until the one-cycle ls_ack pulse.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_STORE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   r_addr_in;
    logic [ADDR_WIDTH-1:0]   r_addr_out;
    logic [63:0]             r_data_out;
    logic [7:0]              r_wstrb;
    logic [2:0]              r_ls_off;
    logic [1:0]              r_ls_size;
    logic                    r_ls_ack;
    logic                    r_ls_err;
    logic [63:0]             r_ls_rdata;
    logic                    r_discard;
    logic [PW-1:0]           r_head;
    logic [PW-1:0]           r_tail;
    logic [CW-1:0]           r_count;
    logic [63:0]             r_q_insn [FETCH_DEPTH];
    logic [ADDR_WIDTH-1:0]   r_q_pc   [FETCH_DEPTH];

    logic [2:0]              w_ls_off;
    logic [2:0]              w_align_mask;
    logic                    w_misalign;
    logic                    w_ls_new;
    logic                    w_fetch_ok;
    logic                    w_push;
    logic                    w_pop;
    logic [63:0]             w_shifted;
    logic [63:0]             w_load_data;
    logic [63:0]             w_store_data;
    logic [7:0]              w_store_strb;

    assign w_ls_off   = i_ls_addr[2:0];
    assign w_misalign = |(w_ls_off & w_align_mask);
    // The request is still high while its ack is on the port; it only counts again afterwards.
    assign w_ls_new   = i_ls_req && !r_ls_ack;
    assign w_fetch_ok = (r_count < CW'(FETCH_DEPTH)) && !i_redir_valid;
    assign w_push     = (r_state == S_FETCH) && i_rdy && !r_discard && !i_redir_valid;
    assign w_pop      = o_if_valid && i_if_ready && !i_redir_valid;
    assign w_shifted  = i_data_in >> {r_ls_off, 3'b000};

    always_comb begin
        w_align_mask = 3'b111;
        w_load_data  = w_shifted;
        w_store_data = i_ls_wdata;
        w_store_strb = 8'hFF << w_ls_off;
        case (i_ls_size)
            2'b00: begin
                w_align_mask = 3'b000;
                w_store_data = {8{i_ls_wdata[7:0]}};
                w_store_strb = 8'h01 << w_ls_off;
            end
            2'b01: begin
                w_align_mask = 3'b001;
                w_store_data = {4{i_ls_wdata[15:0]}};
                w_store_strb = 8'h03 << w_ls_off;
            end
            2'b10: begin
                w_align_mask = 3'b011;
                w_store_data = {2{i_ls_wdata[31:0]}};
                w_store_strb = 8'h0F << w_ls_off;
            end
            default: ;
        endcase
        case (r_ls_size)
            2'b00:   w_load_data = {56'd0, w_shifted[7:0]};
            2'b01:   w_load_data = {48'd0, w_shifted[15:0]};
            2'b10:   w_load_data = {32'd0, w_shifted[31:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ls_new) begin
                    if (!w_misalign) w_next_state = i_ls_we ? S_STORE : S_LOAD;
                end else if (w_fetch_ok) begin
                    w_next_state = S_FETCH;
                end
            end
            default: if (i_rdy) w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_addr_in  <= '0;
            r_addr_out <= '0;
            r_data_out <= '0;
            r_wstrb    <= '0;
            r_ls_off   <= '0;
            r_ls_size  <= '0;
            r_ls_ack   <= 1'b0;
            r_ls_err   <= 1'b0;
            r_ls_rdata <= '0;
            r_discard  <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_state  <= w_next_state;
            r_ls_ack <= 1'b0;
            r_ls_err <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_ls_new && w_misalign) begin
                    r_ls_ack <= 1'b1;
                    r_ls_err <= 1'b1;
                end else if (w_next_state == S_LOAD) begin
                    r_addr_in <= i_ls_addr & ALIGN_MASK;
                    r_ls_off  <= w_ls_off;
                    r_ls_size <= i_ls_size;
                end else if (w_next_state == S_STORE) begin
                    r_addr_out <= i_ls_addr & ALIGN_MASK;
                    r_data_out <= w_store_data;
                    r_wstrb    <= w_store_strb;
                end else if (w_next_state == S_FETCH) begin
                    r_addr_in <= r_pc;
                end
            end
            if (r_state == S_LOAD && i_rdy) begin
                r_ls_ack   <= 1'b1;
                r_ls_rdata <= w_load_data;
            end
            if (r_state == S_STORE && i_rdy) r_ls_ack <= 1'b1;

            // A redirected fetch still has to finish on the bus; its word is dropped.
            if (r_state == S_FETCH && i_rdy)               r_discard <= 1'b0;
            else if (r_state == S_FETCH && i_redir_valid)  r_discard <= 1'b1;

            if (i_redir_valid)  r_pc <= i_redir_pc & ALIGN_MASK;
            else if (w_push)    r_pc <= r_pc + ADDR_WIDTH'(8);

            if (i_redir_valid) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + PW'(1);
                if (w_pop)  r_head <= r_head + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_insn[r_tail] <= i_data_in;
            r_q_pc[r_tail]   <= r_addr_in;
        end
    end

    assign o_ce        = (r_state != S_IDLE);
    assign o_we        = (r_state == S_STORE);
    assign o_addr_in   = r_addr_in;
    assign o_addr_out  = r_addr_out;
    assign o_data_out  = r_data_out;
    assign o_wstrb     = (r_state == S_STORE) ? r_wstrb : 8'h00;
    assign o_if_valid  = (r_count != '0);
    assign o_if_insn   = r_q_insn[r_head];
    assign o_if_pc     = r_q_pc[r_head];
    assign o_ls_ack    = r_ls_ack;
    assign o_ls_err    = r_ls_err;
    assign o_ls_rdata  = r_ls_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lobster_dbus_unit.sv
// Directed bench for lobster_dbus_unit: prefetch fill/drain, a load/store vector table,
// and a redirect-during-fetch sequence.
`timescale 1ns/1ps
module tb_lobster_dbus_unit;

    localparam int AW = 36;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_rdy;
    logic          o_ce, o_we;
    logic [AW-1:0] o_addr_in, o_addr_out;
    logic [63:0]   i_data_in, o_data_out;
    logic [7:0]    o_wstrb;
    logic          i_redir_valid;
    logic [AW-1:0] i_redir_pc;
    logic          o_if_valid, i_if_ready;
    logic [63:0]   o_if_insn;
    logic [AW-1:0] o_if_pc;
    logic          i_ls_req, i_ls_we;
    logic [1:0]    i_ls_size;
    logic [AW-1:0] i_ls_addr;
    logic [63:0]   i_ls_wdata;
    logic          o_ls_ack, o_ls_err;
    logic [63:0]   o_ls_rdata;
    logic [1:0]    o_dbg_state;

    logic          use_model;
    logic [63:0]   tb_rdata;
    int            pass_cnt = 0;
    int            total_cnt = 0;

    typedef struct {
        logic          we;
        logic [1:0]    size;
        logic [AW-1:0] addr;
        logic [63:0]   wdata;
        logic [63:0]   sram;
        int            delay;
        logic          exp_err;
        logic [63:0]   exp_rdata;
        logic [AW-1:0] exp_bus_addr;
        logic [7:0]    exp_wstrb;
        logic [63:0]   exp_dout;
    } ls_vec_t;

    ls_vec_t vecs [12];

    lobster_dbus_unit dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rdy(i_rdy),
        .o_ce(o_ce), .o_we(o_we), .o_addr_in(o_addr_in), .i_data_in(i_data_in),
        .o_addr_out(o_addr_out), .o_data_out(o_data_out), .o_wstrb(o_wstrb),
        .i_redir_valid(i_redir_valid), .i_redir_pc(i_redir_pc),
        .o_if_valid(o_if_valid), .i_if_ready(i_if_ready),
        .o_if_insn(o_if_insn), .o_if_pc(o_if_pc),
        .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_size(i_ls_size),
        .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata),
        .o_ls_ack(o_ls_ack), .o_ls_rdata(o_ls_rdata), .o_ls_err(o_ls_err),
        .o_dbg_state(o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [63:0] insn_of(input logic [AW-1:0] a);
        return {~a[27:0], a};
    endfunction

    assign i_data_in = use_model ? insn_of(o_addr_in) : tb_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    function automatic ls_vec_t mk(input logic we, input logic [1:0] size, input logic [AW-1:0] addr,
                                   input logic [63:0] wdata, input logic [63:0] sram, input int delay,
                                   input logic err, input logic [63:0] rdata, input logic [AW-1:0] baddr,
                                   input logic [7:0] strb, input logic [63:0] dout);
        ls_vec_t v;
        v.we = we; v.size = size; v.addr = addr; v.wdata = wdata; v.sram = sram; v.delay = delay;
        v.exp_err = err; v.exp_rdata = rdata; v.exp_bus_addr = baddr; v.exp_wstrb = strb;
        v.exp_dout = dout;
        return v;
    endfunction

    task automatic run_ls(input int idx);
        ls_vec_t v;
        bit      seen_ce, got_ack;
        int      waitc, ce_cycles;
        v = vecs[idx];
        seen_ce = 0; got_ack = 0; waitc = 0; ce_cycles = 0;
        i_ls_req = 1'b1; i_ls_we = v.we; i_ls_size = v.size;
        i_ls_addr = v.addr; i_ls_wdata = v.wdata; tb_rdata = v.sram;
        for (int c = 0; c < 20 && !got_ack; c++) begin
            @(negedge i_clk);
            i_rdy = 1'b0;
            if (o_ls_ack) begin
                got_ack = 1;
                check($sformatf("ls%0d_err", idx), 64'(o_ls_err), 64'(v.exp_err));
                if (v.exp_err) check($sformatf("ls%0d_no_ce", idx), 64'(seen_ce), 64'd0);
                else check($sformatf("ls%0d_ce_cycles", idx), 64'(ce_cycles), 64'(v.delay + 1));
                if (!v.we && !v.exp_err) check($sformatf("ls%0d_rdata", idx), o_ls_rdata, v.exp_rdata);
            end else if (o_ce) begin
                ce_cycles++;
                if (!seen_ce) begin
                    seen_ce = 1;
                    check($sformatf("ls%0d_we", idx), 64'(o_we), 64'(v.we));
                    if (v.we) begin
                        check($sformatf("ls%0d_addr_out", idx), 64'(o_addr_out), 64'(v.exp_bus_addr));
                        check($sformatf("ls%0d_wstrb", idx), 64'(o_wstrb), 64'(v.exp_wstrb));
                        check($sformatf("ls%0d_data_out", idx), o_data_out, v.exp_dout);
                    end else begin
                        check($sformatf("ls%0d_addr_in", idx), 64'(o_addr_in), 64'(v.exp_bus_addr));
                    end
                end
                if (waitc == v.delay) i_rdy = 1'b1;
                else waitc++;
            end
        end
        if (!got_ack) check($sformatf("ls%0d_ack_timeout", idx), 64'd0, 64'd1);
        @(negedge i_clk);
        check($sformatf("ls%0d_ack_pulse", idx), 64'({o_ls_ack, o_ce}), 64'd0);
        i_ls_req = 1'b0;
        @(negedge i_clk);
    endtask

    logic [AW-1:0] ce_q [$];
    logic [AW-1:0] pop_pc [$];
    logic [63:0]   pop_insn [$];
    int            pop_cyc [$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(0, 2'b01, 36'h1006, 64'h0, 64'h1122334455667788, 0, 0, 64'h1122, 36'h1000, 8'h00, 64'h0);
        vecs[1]  = mk(1, 2'b00, 36'h2003, 64'hAB, 64'h0, 2, 0, 64'h0, 36'h2000, 8'h08, 64'hABABABABABABABAB);
        vecs[2]  = mk(0, 2'b10, 36'h3002, 64'h0, 64'h0, 0, 1, 64'h0, 36'h0, 8'h00, 64'h0);
        vecs[3]  = mk(0, 2'b11, 36'h5000, 64'h0, 64'hDEADBEEF01234567, 1, 0, 64'hDEADBEEF01234567, 36'h5000, 8'h00, 64'h0);
        vecs[4]  = mk(0, 2'b00, 36'h5007, 64'h0, 64'h1122334455667788, 0, 0, 64'h11, 36'h5000, 8'h00, 64'h0);
        vecs[5]  = mk(0, 2'b10, 36'h6004, 64'h0, 64'h1122334455667788, 3, 0, 64'h11223344, 36'h6000, 8'h00, 64'h0);
        vecs[6]  = mk(1, 2'b01, 36'h7002, 64'hFFFFFFFFFFFFBEEF, 64'h0, 0, 0, 64'h0, 36'h7000, 8'h0C, 64'hBEEFBEEFBEEFBEEF);
        vecs[7]  = mk(1, 2'b10, 36'h8004, 64'h12345678, 64'h0, 1, 0, 64'h0, 36'h8000, 8'hF0, 64'h1234567812345678);
        vecs[8]  = mk(1, 2'b11, 36'h9000, 64'h0102030405060708, 64'h0, 0, 0, 64'h0, 36'h9000, 8'hFF, 64'h0102030405060708);
        vecs[9]  = mk(1, 2'b11, 36'h9004, 64'h0, 64'h0, 0, 1, 64'h0, 36'h0, 8'h00, 64'h0);
        vecs[10] = mk(0, 2'b01, 36'h1001, 64'h0, 64'h0, 0, 1, 64'h0, 36'h0, 8'h00, 64'h0);
        vecs[11] = mk(0, 2'b00, 36'hA001, 64'h0, 64'h1122334455667788, 0, 0, 64'h77, 36'hA000, 8'h00, 64'h0);

        i_rst = 1'b1; i_rdy = 1'b0; i_redir_valid = 1'b0; i_redir_pc = '0; i_if_ready = 1'b0;
        i_ls_req = 1'b0; i_ls_we = 1'b0; i_ls_size = 2'b00; i_ls_addr = '0; i_ls_wdata = '0;
        use_model = 1'b1; tb_rdata = '0;

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_ce_we", 64'({o_ce, o_we}), 64'd0);
        check("rst_wstrb", 64'(o_wstrb), 64'd0);
        check("rst_ack_err", 64'({o_ls_ack, o_ls_err}), 64'd0);
        check("rst_rdata", o_ls_rdata, 64'd0);
        check("rst_if_valid", 64'(o_if_valid), 64'd0);
        check("rst_state", 64'(o_dbg_state), 64'd0);
        i_rst = 1'b0;
        i_rdy = 1'b1;

        // Fill: four fetches from RESET_PC, then the bus goes quiet
        for (int c = 0; c < 24; c++) begin
            @(negedge i_clk);
            if (o_ce) ce_q.push_back(o_addr_in);
        end
        check("fill_fetch_count", 64'(ce_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("fill_addr%0d", i), 64'((i < ce_q.size()) ? ce_q[i] : '1),
                  64'(36'hF800 + 36'(8 * i)));
        check("fill_if_valid", 64'(o_if_valid), 64'd1);
        check("fill_if_pc", 64'(o_if_pc), 64'h F800);
        check("fill_if_insn", o_if_insn, insn_of(36'hF800));

        // Drain with if_ready held high; steady state settles at one pop per two cycles
        i_if_ready = 1'b1;
        for (int c = 0; c < 80 && pop_pc.size() < 10; c++) begin
            if (o_if_valid) begin
                pop_pc.push_back(o_if_pc);
                pop_insn.push_back(o_if_insn);
                pop_cyc.push_back(c);
            end
            @(negedge i_clk);
        end
        i_if_ready = 1'b0;
        check("drain_pop_count", 64'(pop_pc.size()), 64'd10);
        for (int i = 0; i < pop_pc.size(); i++) begin
            check($sformatf("drain_pc%0d", i), 64'(pop_pc[i]), 64'(36'hF800 + 36'(8 * i)));
            check($sformatf("drain_insn%0d", i), pop_insn[i], insn_of(36'hF800 + 36'(8 * i)));
        end
        for (int i = 7; i < pop_cyc.size(); i++)
            check($sformatf("drain_gap%0d", i), 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd2);
        repeat (20) @(negedge i_clk);
        check("refill_full", 64'(o_if_valid), 64'd1);

        // Load/store table, queue full so no fetch competes for the bus
        use_model = 1'b0;
        i_rdy = 1'b0;
        for (int i = 0; i < 12; i++) run_ls(i);

        // Redirect while a fetch is stalled on rdy
        use_model = 1'b1;
        i_if_ready = 1'b1;
        @(negedge i_clk);
        i_if_ready = 1'b0;
        begin
            bit found;
            found = 0;
            for (int c = 0; c < 10 && !found; c++) begin
                @(negedge i_clk);
                if (o_ce) found = 1;
            end
            check("redir_fetch_started", 64'(found), 64'd1);
        end
        check("redir_stale_addr_is_old", 64'(o_addr_in[15:12] == 4'hF), 64'd1);
        i_redir_valid = 1'b1;
        i_redir_pc = 36'h4005;
        @(negedge i_clk);
        i_redir_valid = 1'b0;
        check("redir_flush", 64'(o_if_valid), 64'd0);
        check("redir_ce_held", 64'(o_ce), 64'd1);
        repeat (2) @(negedge i_clk);
        i_rdy = 1'b1;
        @(negedge i_clk);
        check("redir_stale_dropped", 64'(o_if_valid), 64'd0);
        begin
            bit found;
            found = 0;
            for (int c = 0; c < 10 && !found; c++) begin
                @(negedge i_clk);
                if (o_if_valid) found = 1;
            end
            check("redir_refetch", 64'(found), 64'd1);
        end
        check("redir_if_pc", 64'(o_if_pc), 64'h4000);
        check("redir_if_insn", o_if_insn, insn_of(36'h4000));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
